// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder sequencer around an external 1-bit fullAdder, LSB first.
// WIDTH+2 cycles per operation; start is only accepted in IDLE, no backpressure otherwise.
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    bitcnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             cout_out_q;
  logic [WIDTH-1:0] sum_d;
  logic             run;

  // New sum bit enters at the MSB; the shift form also covers WIDTH=1.
  assign sum_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
  assign run   = (state_q == RUN);

  assign fa_a     = run & a_sh_q[0];
  assign fa_b     = run & b_sh_q[0];
  assign fa_cin   = run & carry_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_out_q;
  assign cout_out = cout_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      bitcnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= a_in;
            b_sh_q   <= b_in;
            carry_q  <= cin_in;
            bitcnt_q <= '0;
            sum_sh_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_d;
          carry_q  <= fa_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          bitcnt_q <= bitcnt_q + CW'(1);
          if (bitcnt_q == LAST) begin
            sum_out_q  <= sum_d;
            cout_out_q <= fa_cout;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
